// File: rtl/sha_pad_stream.sv
// ---------------------------------------------------------------------------
// sha_pad_stream
//
// Streaming SHA-256 message padder. 32-bit big-endian message words are
// packed into a 512-bit block buffer. When the message ends, the 0x80 marker
// is appended, the remaining bytes are zeroed, and the 64-bit bit-length is
// placed in [63:0]. If the length does not fit behind the data, a separate
// length-only block is emitted.
//
// Parameters
//   LEN_W      message bit-length counter width (16..64). The counter is
//              zero-extended into the 64-bit length field and wraps silently.
//
// Ports
//   clk        clock, all state updates on the rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   input word valid
//   in_ready   block accepts an input word (high only while filling)
//   in_data    message word, first byte in [31:24]
//   in_last    word is the final word of the message
//   in_bytes   valid bytes (1..4, MSB-aligned) in the final word
//   out_valid  out_block valid
//   out_ready  consumer accepts the block
//   out_block  padded block, word 0 in [511:480], length field in [63:0]
//   out_last   block is the final block of the message
//   busy       high from the first accepted word until the final block
//              handshake
//
// Build option
//   SHA_PAD_BYTE_EN  when defined, in_bytes is honoured on the final word.
//                    When undefined, every final word counts as 4 bytes and
//                    in_bytes is ignored.
// ---------------------------------------------------------------------------
module sha_pad_stream #(
    parameter int LEN_W = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [31:0]  in_data,
    input  logic         in_last,
    input  logic [2:0]   in_bytes,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [511:0] out_block,
    output logic         out_last,
    output logic         busy
);

    typedef enum logic [1:0] {
        FILL   = 2'd0,
        PAD    = 2'd1,
        EMIT   = 2'd2,
        LENBLK = 2'd3
    } state_t;

    // Zero-extend the bit counter into the 64-bit SHA-256 length field.
    function automatic logic [63:0] len_field(input logic [LEN_W-1:0] cnt);
        logic [63:0] f;
        f            = 64'd0;
        f[LEN_W-1:0] = cnt;
        return f;
    endfunction

    // Registered state
    state_t             state_r;
    logic [3:0]         idx_r;
    logic [LEN_W-1:0]   cnt_r;
    logic [511:0]       buf_r;
    logic [6:0]         pos_r;       // message bytes in the final data block (1..64)
    logic               len_pend_r;  // length still owed in a LENBLK block
    logic               defer_r;     // 0x80 marker owed at LENBLK byte 0
    logic               out_valid_r;
    logic               out_last_r;
    logic               busy_r;
    logic               in_ready_r;

    // Next-state values
    state_t             state_s;
    logic [3:0]         idx_s;
    logic [LEN_W-1:0]   cnt_s;
    logic [511:0]       buf_s;
    logic [6:0]         pos_s;
    logic               len_pend_s;
    logic               defer_s;
    logic               last_s;
    logic               busy_s;

    logic               xfer_s;
    logic [2:0]         nb_s;
    logic [LEN_W-1:0]   inc_s;

`ifndef SHA_PAD_BYTE_EN
    logic               unused_bytes_s;
    assign unused_bytes_s = ^in_bytes;
`endif

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_block = buf_r;
    assign out_last  = out_last_r;
    assign busy      = busy_r;

    // Byte count of the word being accepted and the matching bit increment.
    always_comb begin
        xfer_s = in_valid & in_ready_r;
`ifdef SHA_PAD_BYTE_EN
        if (in_last && (in_bytes >= 3'd1) && (in_bytes <= 3'd4)) begin
            nb_s = in_bytes;
        end else begin
            // Non-final words are always full; an illegal count is treated as full.
            nb_s = 3'd4;
        end
`else
        nb_s = 3'd4;
`endif
        inc_s = {{(LEN_W-6){1'b0}}, nb_s, 3'b000};
    end

    // Next-state and datapath update logic for the padding FSM.
    always_comb begin
        state_s    = state_r;
        idx_s      = idx_r;
        cnt_s      = cnt_r;
        buf_s      = buf_r;
        pos_s      = pos_r;
        len_pend_s = len_pend_r;
        defer_s    = defer_r;
        last_s     = out_last_r;
        busy_s     = busy_r;

        case (state_r)
            FILL: begin
                if (xfer_s) begin
                    buf_s[9'd511 - {idx_r, 5'd0} -: 32] = in_data;
                    idx_s  = idx_r + 4'd1;
                    cnt_s  = cnt_r + inc_s;
                    busy_s = 1'b1;
                    if (in_last) begin
                        pos_s   = {1'b0, idx_r, 2'b00} + {4'd0, nb_s};
                        state_s = PAD;
                    end else if (idx_r == 4'd15) begin
                        state_s = EMIT;
                    end else begin
                        state_s = FILL;
                    end
                end else begin
                    state_s = FILL;
                end
            end

            PAD: begin
                // Marker at byte pos_r, zeros after it. pos_r = 64 leaves the
                // block untouched and defers the marker to the length block.
                for (int p = 0; p < 64; p++) begin
                    if (7'(p) == pos_r) begin
                        buf_s[511-8*p -: 8] = 8'h80;
                    end else if (7'(p) > pos_r) begin
                        buf_s[511-8*p -: 8] = 8'h00;
                    end else begin
                        buf_s[511-8*p -: 8] = buf_r[511-8*p -: 8];
                    end
                end
                if (pos_r <= 7'd55) begin
                    buf_s[63:0] = len_field(cnt_r);
                    last_s      = 1'b1;
                    len_pend_s  = 1'b0;
                    defer_s     = 1'b0;
                end else begin
                    last_s      = 1'b0;
                    len_pend_s  = 1'b1;
                    defer_s     = (pos_r == 7'd64);
                end
                state_s = EMIT;
            end

            EMIT: begin
                if (out_ready) begin
                    if (len_pend_r) begin
                        state_s = LENBLK;
                    end else begin
                        state_s = FILL;
                        buf_s   = 512'd0;
                        idx_s   = 4'd0;
                        last_s  = 1'b0;
                        if (out_last_r) begin
                            cnt_s  = {LEN_W{1'b0}};
                            busy_s = 1'b0;
                        end else begin
                            cnt_s  = cnt_r;
                        end
                    end
                end else begin
                    state_s = EMIT;
                end
            end

            LENBLK: begin
                buf_s = 512'd0;
                if (defer_r) begin
                    buf_s[511:504] = 8'h80;
                end else begin
                    buf_s[511:504] = 8'h00;
                end
                buf_s[63:0] = len_field(cnt_r);
                last_s      = 1'b1;
                len_pend_s  = 1'b0;
                defer_s     = 1'b0;
                state_s     = EMIT;
            end

            default: begin
                state_s    = FILL;
                idx_s      = 4'd0;
                cnt_s      = {LEN_W{1'b0}};
                buf_s      = 512'd0;
                pos_s      = 7'd0;
                len_pend_s = 1'b0;
                defer_s    = 1'b0;
                last_s     = 1'b0;
                busy_s     = 1'b0;
            end
        endcase
    end

    // State, buffer and registered output flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= FILL;
            idx_r       <= 4'd0;
            cnt_r       <= {LEN_W{1'b0}};
            buf_r       <= 512'd0;
            pos_r       <= 7'd0;
            len_pend_r  <= 1'b0;
            defer_r     <= 1'b0;
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
            busy_r      <= 1'b0;
            in_ready_r  <= 1'b0;
        end else begin
            state_r     <= state_s;
            idx_r       <= idx_s;
            cnt_r       <= cnt_s;
            buf_r       <= buf_s;
            pos_r       <= pos_s;
            len_pend_r  <= len_pend_s;
            defer_r     <= defer_s;
            out_valid_r <= (state_s == EMIT);
            out_last_r  <= last_s;
            busy_r      <= busy_s;
            in_ready_r  <= (state_s == FILL);
        end
    end

endmodule
